// File: rtl/sqrt_proc.sv
// Datapath for the square-root FSM: load-strobed working registers around a small
// adder ALU, a status word back to the FSM, and a valid/ready result register.
module sqrt_proc #(
    parameter int DW = 8,
    parameter int RW = 8
) (
    input  logic            clk,
    input  logic            rstn_i,
    input  logic [DW-1:0]   operand_i,
    input  logic [9:0]      bus_ctrl,
    output logic [2*DW:0]   bus_proc,
    output logic [RW-1:0]   res_o,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic            ovf_o,
    output logic            sel_err_o
);

    localparam int SW = DW + 1;

    localparam logic [3:0] SEL_ZERO = 4'd0;
    localparam logic [3:0] SEL_INC1 = 4'd1;
    localparam logic [3:0] SEL_INC2 = 4'd2;
    localparam logic [3:0] SEL_ACC  = 4'd4;
    localparam logic [3:0] SEL_SUM  = 4'd8;

    localparam logic [SW:0] ONE_W = (SW+1)'(1);
    localparam logic [SW:0] TWO_W = (SW+1)'(2);

    logic          clr;
    logic          s_ld;
    logic          d_ld;
    logic          r_ld;
    logic          reg1_ld;
    logic          reg2_ld;
    logic [3:0]    sel;

    logic [DW-1:0] a_q;
    logic [SW-1:0] s_q;
    logic [SW-1:0] d_q;
    logic [SW-1:0] reg1_q;
    logic [SW-1:0] reg2_q;

    logic [SW:0]   sum;
    logic [SW-1:0] y;
    logic          carry;
    logic          any_wld;
    logic          any_ld;
    logic          r_ld_eff;
    logic          unused_d;

    function automatic logic sel_legal(input logic [3:0] code);
        case (code)
            SEL_ZERO, SEL_INC1, SEL_INC2, SEL_ACC, SEL_SUM: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Sum is one bit wider than the working registers so the carry-out is kept.
    function automatic logic [SW:0] alu_sum(
        input logic [3:0]    code,
        input logic [SW-1:0] s_v,
        input logic [SW-1:0] r1_v,
        input logic [SW-1:0] r2_v
    );
        case (code)
            SEL_INC1: return {1'b0, r1_v} + ONE_W;
            SEL_INC2: return {1'b0, r2_v} + TWO_W;
            SEL_ACC:  return {1'b0, s_v}  + {1'b0, r2_v};
            SEL_SUM:  return {1'b0, r1_v} + {1'b0, r2_v};
            default:  return '0;
        endcase
    endfunction

    assign clr     = bus_ctrl[0];
    assign s_ld    = bus_ctrl[1];
    assign d_ld    = bus_ctrl[2];
    assign r_ld    = bus_ctrl[3];
    assign reg1_ld = bus_ctrl[4];
    assign reg2_ld = bus_ctrl[5];
    assign sel     = bus_ctrl[9:6];

    assign sum      = alu_sum(sel, s_q, reg1_q, reg2_q);
    assign y        = sum[SW-1:0];
    assign carry    = sum[SW];
    assign any_wld  = s_ld | d_ld | reg1_ld | reg2_ld;
    assign any_ld   = any_wld | r_ld;
    assign r_ld_eff = r_ld & ~clr;

    assign bus_proc = {a_q, s_q};
    assign unused_d = ^d_q;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            a_q       <= '0;
            s_q       <= '0;
            d_q       <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            ovf_o     <= 1'b0;
            sel_err_o <= 1'b0;
        end else if (clr) begin
            a_q       <= operand_i;
            s_q       <= '0;
            d_q       <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            ovf_o     <= 1'b0;
            sel_err_o <= 1'b0;
        end else begin
            if (s_ld)    s_q    <= y;
            if (d_ld)    d_q    <= y;
            if (reg1_ld) reg1_q <= y;
            if (reg2_ld) reg2_q <= y;
            if (any_wld && carry)          ovf_o     <= 1'b1;
            if (any_ld && !sel_legal(sel)) sel_err_o <= 1'b1;
        end
    end

    // Result capture samples D before any same-cycle d_ld; a new capture beats acceptance.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            res_o       <= '0;
            res_valid_o <= 1'b0;
        end else if (r_ld_eff) begin
            res_o       <= d_q[RW:1];
            res_valid_o <= 1'b1;
        end else if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sqrt_proc.sv
// Directed bench for sqrt_proc: integer-arithmetic reference model compared every
// cycle, plus hand-computed literal expectations at key points.
module tb_sqrt_proc;

    localparam int DW = 8;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rstn_i = 1'b1;
    logic [DW-1:0] operand_i = '0;
    logic [9:0]    bus_ctrl = '0;
    logic [2*DW:0] bus_proc;
    logic [RW-1:0] res_o;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic          ovf_o;
    logic          sel_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    int m_a = 0, m_s = 0, m_d = 0, m_r1 = 0, m_r2 = 0, m_res = 0;
    bit m_vld = 0, m_ovf = 0, m_err = 0;
    int m_sum;

    always #5 clk = ~clk;

    sqrt_proc #(.DW(DW), .RW(RW)) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .operand_i   (operand_i),
        .bus_ctrl    (bus_ctrl),
        .bus_proc    (bus_proc),
        .res_o       (res_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .ovf_o       (ovf_o),
        .sel_err_o   (sel_err_o)
    );

    // Unreduced sum (0..1022); values >= 512 mean a carry-out.
    function automatic int alu(int code, int s, int r1, int r2);
        case (code)
            1:       return r1 + 1;
            2:       return r2 + 2;
            4:       return s + r2;
            8:       return r1 + r2;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(int code);
        return (code == 0) || (code == 1) || (code == 2) || (code == 4) || (code == 8);
    endfunction

    always_comb m_sum = alu(int'(bus_ctrl[9:6]), m_s, m_r1, m_r2);

    always @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            m_a <= 0; m_s <= 0; m_d <= 0; m_r1 <= 0; m_r2 <= 0;
            m_res <= 0; m_vld <= 0; m_ovf <= 0; m_err <= 0;
        end else begin
            if (bus_ctrl[0]) begin
                m_a <= int'(operand_i);
                m_s <= 0; m_d <= 0; m_r1 <= 0; m_r2 <= 0;
                m_ovf <= 0; m_err <= 0;
            end else begin
                if (bus_ctrl[1]) m_s  <= m_sum % 512;
                if (bus_ctrl[2]) m_d  <= m_sum % 512;
                if (bus_ctrl[4]) m_r1 <= m_sum % 512;
                if (bus_ctrl[5]) m_r2 <= m_sum % 512;
                if ((bus_ctrl[1] | bus_ctrl[2] | bus_ctrl[4] | bus_ctrl[5]) && m_sum >= 512)
                    m_ovf <= 1;
                if ((bus_ctrl[1] | bus_ctrl[2] | bus_ctrl[3] | bus_ctrl[4] | bus_ctrl[5])
                    && !legal(int'(bus_ctrl[9:6])))
                    m_err <= 1;
            end
            if (bus_ctrl[3] && !bus_ctrl[0]) begin
                m_res <= m_d / 2;
                m_vld <= 1;
            end else if (m_vld && res_ready_i) begin
                m_vld <= 0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("mdl_bus_proc", 32'(bus_proc), 32'(m_a * 512 + m_s));
        check("mdl_res",      32'(res_o), 32'(m_res));
        check("mdl_valid",    32'(res_valid_o), 32'(m_vld));
        check("mdl_ovf",      32'(ovf_o), 32'(m_ovf));
        check("mdl_sel_err",  32'(sel_err_o), 32'(m_err));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic op(input bit c, input bit s, input bit d, input bit r,
                      input bit r1, input bit r2, input int code);
        bus_ctrl = {4'(code), r2, r1, r, d, s, c};
        cyc();
        bus_ctrl = '0;
    endtask

    initial begin
        #1 rstn_i = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            bus_ctrl    = 10'($urandom);
            operand_i   = 8'($urandom);
            res_ready_i = 1'($urandom);
        end
        #2;
        check("rst_bus_proc", 32'(bus_proc), 0);
        check("rst_res",      32'(res_o), 0);
        check("rst_valid",    32'(res_valid_o), 0);
        check("rst_ovf",      32'(ovf_o), 0);
        check("rst_sel_err",  32'(sel_err_o), 0);

        @(posedge clk);
        #1;
        bus_ctrl = '0;
        res_ready_i = 1'b0;
        rstn_i = 1'b1;
        operand_i = 8'd200;
        op(1, 0, 0, 0, 0, 0, 0);
        check("clr_bus_proc", 32'(bus_proc), 32'h19000);

        op(0, 0, 0, 0, 1, 0, 1);
        op(0, 0, 0, 0, 0, 1, 8);
        op(0, 0, 0, 0, 0, 1, 2);
        op(0, 1, 0, 0, 0, 0, 4);
        check("s_acc3", 32'(bus_proc[8:0]), 3);
        op(0, 1, 1, 0, 0, 0, 8);
        check("s_sum4", 32'(bus_proc[8:0]), 4);

        op(0, 0, 0, 0, 0, 1, 4);
        op(0, 0, 1, 0, 0, 0, 2);
        op(0, 0, 0, 1, 0, 0, 0);
        check("rld_res4", 32'(res_o), 4);
        check("rld_valid", 32'(res_valid_o), 1);
        repeat (3) begin
            cyc();
            check("hold_res4", 32'(res_o), 4);
            check("hold_valid", 32'(res_valid_o), 1);
        end
        res_ready_i = 1'b1;
        cyc();
        check("accept_valid0", 32'(res_valid_o), 0);
        res_ready_i = 1'b0;

        op(0, 0, 0, 1, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 1);
        op(0, 0, 0, 0, 1, 0, 8);
        op(0, 0, 1, 0, 0, 0, 1);
        check("stable_res4", 32'(res_o), 4);
        res_ready_i = 1'b1;
        op(0, 0, 0, 1, 0, 0, 0);
        check("rld_acc_res5", 32'(res_o), 5);
        check("rld_acc_valid", 32'(res_valid_o), 1);
        res_ready_i = 1'b0;
        op(0, 0, 1, 1, 0, 0, 2);
        check("rld_pre_d_res5", 32'(res_o), 5);
        op(0, 0, 0, 1, 0, 0, 0);
        check("rld_new_d_res4", 32'(res_o), 4);

        op(0, 0, 0, 1, 0, 0, 15);
        check("rld_bad_sel_err", 32'(sel_err_o), 1);
        op(0, 0, 1, 0, 0, 0, 1);
        operand_i = 8'h5A;
        op(1, 0, 0, 1, 0, 0, 0);
        check("clr_rld_res", 32'(res_o), 4);
        check("clr_rld_bus", 32'(bus_proc), 32'hB400);
        check("clr_rld_err", 32'(sel_err_o), 0);

        op(0, 0, 0, 0, 1, 0, 1);
        op(0, 0, 0, 0, 0, 1, 8);
        op(0, 0, 0, 0, 0, 1, 2);
        repeat (170) op(0, 1, 0, 0, 0, 0, 4);
        check("s_510", 32'(bus_proc[8:0]), 510);
        check("ovf_before", 32'(ovf_o), 0);
        op(0, 1, 0, 0, 0, 0, 4);
        check("s_wrap1", 32'(bus_proc[8:0]), 1);
        check("ovf_set", 32'(ovf_o), 1);
        repeat (2) cyc();
        check("ovf_sticky", 32'(ovf_o), 1);

        op(0, 0, 0, 0, 1, 0, 3);
        check("bad_sel_err", 32'(sel_err_o), 1);
        op(0, 1, 0, 0, 0, 0, 1);
        check("bad_sel_reg1_0", 32'(bus_proc[8:0]), 1);
        operand_i = 8'h33;
        op(1, 0, 0, 0, 1, 0, 1);
        check("clr_ld_bus", 32'(bus_proc), 32'(8'h33) * 512);
        check("clr_ld_ovf", 32'(ovf_o), 0);
        check("clr_ld_err", 32'(sel_err_o), 0);
        op(0, 1, 0, 0, 0, 0, 1);
        check("clr_ld_reg1_0", 32'(bus_proc[8:0]), 1);

        repeat (36) op(0, 0, 0, 0, 1, 0, 1);
        op(0, 1, 0, 0, 0, 0, 1);
        op(0, 0, 0, 1, 0, 0, 0);
        check("pre_rst_s37", 32'(bus_proc[8:0]), 37);
        check("pre_rst_valid", 32'(res_valid_o), 1);
        #3 rstn_i = 1'b0;
        #1;
        check("arst_bus_proc", 32'(bus_proc), 0);
        check("arst_res", 32'(res_o), 0);
        check("arst_valid", 32'(res_valid_o), 0);
        check("arst_ovf", 32'(ovf_o), 0);
        check("arst_sel_err", 32'(sel_err_o), 0);
        @(posedge clk);
        #1 rstn_i = 1'b1;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sqrt_proc.md
Name: sqrt_proc

Overview:
- Datapath partner of the square-root control FSM.
- Consumes the 10-bit control word bus_ctrl: register load strobes plus a 4-bit ALU selector.
- Returns the 17-bit status word bus_proc = {operand, square accumulator}, which the FSM compares.
- Captures the final root into a result register and offers it to downstream logic over a valid/ready handshake.

Parameters:
DW, 8, operand width; internal working width SW = DW+1; bus_proc width 2*DW+1
RW, 8, result width; result = D_q[RW:1]

Ports:
clk  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
operand_i  in  DW  radicand; sampled every cycle clr is high
bus_ctrl  in  10  [0] clr, [1] s_ld, [2] d_ld, [3] r_ld, [4] reg1_ld, [5] reg2_ld, [9:6] sel
bus_proc  out  2*DW+1  {A_q, S_q}; [16:9] operand, [8:0] square accumulator
res_o  out  RW  result register
res_valid_o  out  1  result available
res_ready_i  in  1  downstream accepts result
ovf_o  out  1  sticky adder carry-out flag
sel_err_o  out  1  sticky illegal-selector flag

Behaviour:
- Clock and reset: clk; reset rstn_i, asynchronous, active-low.
- Reset: A_q, S_q, D_q, REG1_q, REG2_q, res_o, res_valid_o, ovf_o, sel_err_o all 0.
- Registers: A_q[DW-1:0]; S_q, D_q, REG1_q, REG2_q [SW-1:0].
- ALU output y (SW bits, combinational) by sel:
  - 0: y = 0
  - 1: y = REG1 + 1
  - 2: y = REG2 + 2
  - 4: y = S + REG2
  - 8: y = REG1 + REG2
  - any other code: y = 0
- Arithmetic: SW-bit, wraps mod 2^SW. Carry c = bit SW of the SW+1-bit sum.
- Loads take effect at posedge (1-cycle latency). bus_proc reflects registers directly, with no extra stage.
  - s_ld: S_q <= y
  - d_ld: D_q <= y
  - reg1_ld: REG1_q <= y
  - reg2_ld: REG2_q <= y
  - Several strobes in one cycle all load the same y.
- clr: has priority over every load strobe in the same cycle.
  - A_q <= operand_i.
  - S_q, D_q, REG1_q, REG2_q <= 0.
  - ovf_o, sel_err_o <= 0.
  - res_o and res_valid_o are untouched.
- Flags:
  - ovf_o set when (s_ld|d_ld|reg1_ld|reg2_ld) & c & ~clr.
  - sel_err_o set when any load strobe (including r_ld) is high with sel not in {0,1,2,4,8}, and ~clr.
  - Both flags hold until clr or reset.
- Result handshake:
  - r_ld & ~clr: res_o <= D_q[RW:1] (pre-update D_q; a d_ld in the same cycle does not affect the captured value); res_valid_o <= 1.
  - res_valid_o & res_ready_i & ~r_ld: res_valid_o <= 0.
  - r_ld and acceptance in the same cycle: new value loaded, res_valid_o stays 1.
  - res_o stable while res_valid_o=1 and no r_ld.
  - r_ld while valid and not ready: overwrite; no stall back to the FSM.
- Simultaneous clr with r_ld: clr wins for datapath registers and flags; r_ld is ignored.
- Reset mid-operation: immediate clear of everything, including a pending result.

Test Plan:
- Reset: rstn_i=0 with random inputs -> bus_proc=0, res_o=0, res_valid_o=0, ovf_o=0, sel_err_o=0. Release, then clr=1 with operand_i=8'd200 -> next cycle bus_proc=17'h19000.
- ALU chain after clr:
  - reg1_ld, sel=1 -> REG1=1
  - reg2_ld, sel=8 -> REG2=1
  - reg2_ld, sel=2 -> REG2=3
  - s_ld, sel=4 -> S=3; bus_proc[8:0]=3 visible the cycle after the load
  - s_ld|d_ld, sel=8 -> S=D=4
- Result handshake:
  - D=9'd9; r_ld with res_ready_i=0 -> res_o=4, res_valid_o=1; held 3 cycles.
  - res_ready_i=1 -> res_valid_o=0 next cycle.
  - D=10; r_ld with res_ready_i=1 -> res_o=5, res_valid_o stays 1.
- Overflow: S=9'd510, REG2=3; s_ld, sel=4 -> S=1, ovf_o=1; stays 1 until clr.
- Illegal selector: reg1_ld, sel=3 -> REG1=0, sel_err_o=1. clr together with reg1_ld, sel=1 -> all working registers 0, flags 0, A_q=operand_i.
- Async reset mid-op: res_valid_o=1, S=37; assert rstn_i between clock edges -> all outputs 0 immediately, without waiting for clk.
